seven_seg_scan: RTL

Time-multiplexing scanner that sits directly upstream of the combinational seven-segment decoder. It holds an 8-digit hex value plus per-digit decimal-point and enable masks. It walks one digit slot at a time and presents the decoder with the active nibble, a one-hot active-high anode select and the active-high dp bit. New display data is taken through a load strobe and committed only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/seven_seg_scan.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan.sv
// Time-multiplexing scanner feeding a seven-segment decoder: walks N_DIG slots,
// double-buffers display data and commits staged updates only at frame wraps.
module seven_seg_scan #(
    parameter int TICK_DIV  = 100000,
    parameter int BLANK_CYC = 1000,
    parameter int N_DIG     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in_mask,
    input  logic [7:0]  en_mask,
    output logic [3:0]  digit,
    output logic [7:0]  an_sel,
    output logic        dp_out,
    output logic        load_pending,
    output logic        frame_start
);

    localparam int              CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
    localparam logic [2:0]       IDX_MAX   = 3'(N_DIG - 1);
    localparam logic [7:0]       DIG_MASK  = 8'((16'd1 << N_DIG) - 16'd1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      stg_data_q, stg_data_d, shd_data_q, shd_data_d;
    logic [7:0]       stg_dp_q, stg_dp_d, shd_dp_q, shd_dp_d;
    logic [7:0]       stg_en_q, stg_en_d, shd_en_q, shd_en_d;
    logic             pending_q, pending_d;
    logic             wrapped_q, wrapped_d;
    logic [3:0]       digit_q, digit_d;
    logic [7:0]       an_sel_q, an_sel_d;
    logic             dp_q, dp_d;
    logic             fs_q, fs_d;

    logic slot_end_s;
    logic frame_wrap_s;
    logic en_bit_s;

    // Next-state: prescaler/slot walk, staging capture and frame-boundary commit
    always_comb begin
        slot_end_s   = (cnt_q == CNT_MAX);
        frame_wrap_s = slot_end_s && (idx_q == IDX_MAX);
        cnt_d        = slot_end_s ? '0 : cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        wrapped_d    = frame_wrap_s;
        stg_data_d   = stg_data_q;
        stg_dp_d     = stg_dp_q;
        stg_en_d     = stg_en_q;
        shd_data_d   = shd_data_q;
        shd_dp_d     = shd_dp_q;
        shd_en_d     = shd_en_q;
        pending_d    = pending_q;

        if (frame_wrap_s) begin
            idx_d = 3'd0;
        end else if (slot_end_s) begin
            idx_d = idx_q + 3'd1;
        end else begin
            idx_d = idx_q;
        end

        if (load) begin
            stg_data_d = data_in;
            stg_dp_d   = dp_in_mask;
            stg_en_d   = en_mask;
        end else begin
            stg_data_d = stg_data_q;
        end

        // A load landing on the wrap edge bypasses staging so it shows immediately
        if (frame_wrap_s && load) begin
            shd_data_d = data_in;
            shd_dp_d   = dp_in_mask;
            shd_en_d   = en_mask;
            pending_d  = 1'b0;
        end else if (frame_wrap_s && pending_q) begin
            shd_data_d = stg_data_q;
            shd_dp_d   = stg_dp_q;
            shd_en_d   = stg_en_q;
            pending_d  = 1'b0;
        end else if (load) begin
            pending_d  = 1'b1;
        end else begin
            pending_d  = pending_q;
        end
    end

    // Output decode from the current slot; registered one cycle later
    always_comb begin
        en_bit_s = shd_en_q[idx_q];
        digit_d  = shd_data_q[{idx_q, 2'b00} +: 4];
        dp_d     = shd_dp_q[idx_q] & en_bit_s;
        fs_d     = wrapped_q;
        if ((cnt_q < BLANK_LIM) || !en_bit_s) begin
            an_sel_d = 8'h00;
        end else begin
            an_sel_d = (8'h01 << idx_q) & DIG_MASK;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            idx_q      <= 3'd0;
            stg_data_q <= 32'h0000_0000;
            stg_dp_q   <= 8'h00;
            stg_en_q   <= 8'h00;
            shd_data_q <= 32'h0000_0000;
            shd_dp_q   <= 8'h00;
            shd_en_q   <= 8'h00;
            pending_q  <= 1'b0;
            wrapped_q  <= 1'b0;
            digit_q    <= 4'h0;
            an_sel_q   <= 8'h00;
            dp_q       <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            stg_data_q <= stg_data_d;
            stg_dp_q   <= stg_dp_d;
            stg_en_q   <= stg_en_d;
            shd_data_q <= shd_data_d;
            shd_dp_q   <= shd_dp_d;
            shd_en_q   <= shd_en_d;
            pending_q  <= pending_d;
            wrapped_q  <= wrapped_d;
            digit_q    <= digit_d;
            an_sel_q   <= an_sel_d;
            dp_q       <= dp_d;
            fs_q       <= fs_d;
        end
    end

    assign digit        = digit_q;
    assign an_sel       = an_sel_q;
    assign dp_out       = dp_q;
    assign frame_start  = fs_q;
    assign load_pending = pending_q;

endmodule
